// File: rtl/clk_div_pkg.sv
// Shared types and reset defaults for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } chan_state_e;

  // Power-on divide ratio and high-phase length (divide-by-2, 50% duty).
  localparam int unsigned DEF_D = 2;
  localparam int unsigned DEF_H = 1;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: programmable ratio and high time, glitch-free registered output,
// shadowed reprogramming that only takes effect on a period boundary.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] div_in,
  input  logic [W-1:0] hi_in,
  output logic         q,
  output logic         tick,
  output logic         busy,
  output logic         pend
);

  chan_state_e  state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] d_q, d_d;
  logic [W-1:0] h_q, h_d;
  logic [W-1:0] sd_q, sd_d;
  logic [W-1:0] sh_q, sh_d;
  logic         q_q, q_d;
  logic         tick_q, tick_d;
  logic         busy_q, busy_d;
  logic         pend_q, pend_d;

  logic [W-1:0] ld_d;
  logic [W-1:0] ld_h;
  logic         wrap;

  // Ratios below 2 cannot toggle, so they collapse to divide-by-2.
  function automatic logic [W-1:0] eff_div(input logic [W-1:0] div);
    return (div < W'(2)) ? W'(2) : div;
  endfunction

  // High time of 0 means half the period; otherwise clamp so the low phase is never empty.
  function automatic logic [W-1:0] eff_hi(input logic [W-1:0] hi, input logic [W-1:0] d);
    logic [W-1:0] dm1;
    dm1 = d - W'(1);
    if (hi == '0) begin
      return d >> 1;
    end else if (hi > dm1) begin
      return dm1;
    end else begin
      return hi;
    end
  endfunction

  // Next-state, counter, settings and output computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    h_d     = h_q;
    sd_d    = sd_q;
    sh_d    = sh_q;
    q_d     = q_q;
    tick_d  = 1'b0;
    pend_d  = pend_q;

    ld_d = eff_div(div_in);
    ld_h = eff_hi(hi_in, ld_d);
    wrap = (cnt_q == (d_q - W'(1)));

    case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        q_d    = 1'b0;
        pend_d = 1'b0;
        if (load) begin
          d_d = ld_d;
          h_d = ld_h;
        end
        if (en) begin
          state_d = ST_RUN;
          q_d     = 1'b1;
          tick_d  = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (wrap) begin
          cnt_d = '0;
          if (pend_q) begin
            d_d    = sd_q;
            h_d    = sh_q;
            pend_d = 1'b0;
          end
          if (!en) begin
            // Period finished with no run request: park, and a coincident load needs no shadow.
            state_d = ST_IDLE;
            q_d     = 1'b0;
            if (load) begin
              d_d = ld_d;
              h_d = ld_h;
            end
          end else begin
            state_d = ST_RUN;
            q_d     = 1'b1;
            tick_d  = 1'b1;
            if (load) begin
              sd_d   = ld_d;
              sh_d   = ld_h;
              pend_d = 1'b1;
            end
          end
        end else begin
          cnt_d   = cnt_q + W'(1);
          q_d     = (cnt_d < h_q);
          state_d = en ? ST_RUN : ST_DRAIN;
          if (load) begin
            sd_d   = ld_d;
            sh_d   = ld_h;
            pend_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        q_d     = 1'b0;
        pend_d  = 1'b0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // Channel registers; reset restores divide-by-2 and drops any pending settings.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      d_q     <= W'(DEF_D);
      h_q     <= W'(DEF_H);
      sd_q    <= W'(DEF_D);
      sh_q    <= W'(DEF_H);
      q_q     <= 1'b0;
      tick_q  <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      h_q     <= h_d;
      sd_q    <= sd_d;
      sh_q    <= sh_d;
      q_q     <= q_d;
      tick_q  <= tick_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
    end
  end

  assign q    = q_q;
  assign tick = tick_q;
  assign busy = busy_q;
  assign pend = pend_q;

endmodule

// File: rtl/clk_div_multi.sv
// Bank of NCH independent programmable clock dividers sharing one input clock.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned W   = 8,
  parameter int unsigned NCH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic [NCH-1:0]   load,
  input  logic [NCH*W-1:0] div_in,
  input  logic [NCH*W-1:0] hi_in,
  output logic [NCH-1:0]   q,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   pend
);

  // One channel per bit of the control vectors, each on its own W-bit slice.
  for (genvar i = 0; i < int'(NCH); i++) begin : g_chan
    clk_div_chan #(
      .W(W)
    ) u_chan (
      .clk    (clk),
      .reset  (reset),
      .en     (en[i]),
      .load   (load[i]),
      .div_in (div_in[i*W +: W]),
      .hi_in  (hi_in[i*W +: W]),
      .q      (q[i]),
      .tick   (tick[i]),
      .busy   (busy[i]),
      .pend   (pend[i])
    );
  end

endmodule

// File: doc/clk_div_multi.md
CLK_DIV_MULTI -- requirements
Module: clk_div_multi

Interface
REQ-001 Parameter W, default 8: divisor/high-count width, W >= 2.
REQ-002 Parameter NCH, default 2: number of independent divider channels, NCH >= 1.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  NCH  per-channel run request.
REQ-006 load  input  NCH  per-channel one-cycle strobe capturing div_in/hi_in slice.
REQ-007 div_in  input  NCH*W  divide ratio; channel i at [i*W +: W].
REQ-008 hi_in  input  NCH*W  high-phase length in clk cycles; channel i at [i*W +: W].
REQ-009 q  output  NCH  divided clock, registered, glitch-free.
REQ-010 tick  output  NCH  one-cycle pulse coincident with the first high cycle of each q period.
REQ-011 busy  output  NCH  channel state is not IDLE.
REQ-012 pend  output  NCH  loaded settings waiting for the next period boundary.

Function
REQ-013 Effective ratio D SHALL be max(div,2); div values 0 and 1 SHALL both give divide-by-2.
REQ-014 Effective high count H SHALL be floor(D/2) when hi = 0, else min(hi, D-1); q therefore always toggles.
REQ-015 Each channel SHALL have states IDLE, RUN, DRAIN held in registered state.
REQ-016 IDLE: cnt=0, q=0, tick=0; en=1 SHALL move to RUN at the next edge with cnt=0, q=1, tick=1.
REQ-017 RUN/DRAIN: each edge cnt_next = (cnt == D-1) ? 0 : cnt+1; q <= (cnt_next < H); tick <= (cnt_next == 0).
REQ-018 q SHALL be high for exactly H and low for exactly D-H consecutive cycles per period.
REQ-019 en=0 in RUN SHALL move to DRAIN; the current period SHALL complete, and the wrap edge SHALL go to IDLE (q=0) instead of starting a new period.
REQ-020 en=1 in DRAIN SHALL return to RUN with no interruption of the period.
REQ-021 load in IDLE SHALL write active D/H settings directly; pend stays 0.
REQ-022 load in RUN/DRAIN SHALL write shadow registers and set pend; active settings SHALL update at the next wrap edge, which clears pend.
REQ-023 Multiple loads before a wrap: last load SHALL win.
REQ-024 load on the same edge as a wrap SHALL go to shadow and apply at the following wrap; a shadow pending before that edge SHALL apply at it.
REQ-025 Active settings SHALL never change mid-period; no q pulse shorter than min(H, D-H) cycles.
REQ-026 Channels SHALL be fully independent; no cross-channel coupling.
REQ-027 No combinational path from any input to q, tick, busy or pend.

Reset
REQ-028 reset SHALL force all channels to IDLE, cnt=0, q=0, tick=0, pend=0, active and shadow D=2/H=1, regardless of state or pending loads.
REQ-029 First edge after reset deassertion SHALL follow REQ-016 normally.

Structure
REQ-030 Package clk_div_pkg SHALL hold the state enum (IDLE, RUN, DRAIN) and default constants (D=2, H=1).
REQ-031 One sub-module clk_div_chan SHALL implement a single channel; clk_div_multi SHALL instantiate NCH copies via generate.

Verification
REQ-032 Idle load div=5 hi=0, en=1 -> q pattern 11000 repeating, tick every 5 cycles aligned with first 1.
REQ-033 div=1 hi=7 -> q toggles every cycle (D=2, H=1); div=4 hi=4 -> 1110 repeating.
REQ-034 Running div=4 hi=2, load div=6 hi=3 at cnt=1 -> pend=1, current 1100 completes, then 111000, pend clears at wrap.
REQ-035 Running div=8 hi=4, drop en at cnt=2 -> busy stays 1 until period end, q finishes 11110000, then q=0, busy=0.
REQ-036 Reset asserted mid-period with pend=1 -> outputs 0 immediately, after release and en=1 channel runs divide-by-2.
REQ-037 NCH=2, channel 0 div=3, channel 1 div=7 hi=1, both enabled -> independent periods 3 and 7, ticks coincide every 21 cycles.
